// File: rtl/alu_pipe_reg_if.sv
// Operand/opcode request and result/flag response bundle for alu_pipe_reg.
// The master drives operands and the slave returns the registered results.
interface alu_pipe_reg_if #(parameter int WIDTH = 4);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       sel;
  logic             acc_mode;
  logic             acc_clr;
  logic             out_valid;
  logic [WIDTH-1:0] g;
  logic             carry;
  logic             zero;
  logic             ovf;
  logic [WIDTH-1:0] acc;

  modport master (
    output in_valid, a, b, sel, acc_mode, acc_clr,
    input  out_valid, g, carry, zero, ovf, acc
  );

  modport slave (
    input  in_valid, a, b, sel, acc_mode, acc_clr,
    output out_valid, g, carry, zero, ovf, acc
  );
endinterface

// File: rtl/alu_pipe_reg.sv
// Two-stage select-ALU: S1 captures operands, S2 computes and registers the result and flags.
// An accumulator can stand in for operand A, and acc-mode results are written back into it.
module alu_pipe_reg #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  alu_pipe_reg_if.slave bus
);
  localparam int STAGES = 2;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;
  localparam logic [WIDTH:0] WLIM = (WIDTH+1)'(WIDTH);

  logic [STAGES:1]  vld_pipe;
  logic [WIDTH-1:0] a_s1, b_s1;
  logic [2:0]       sel_s1;
  logic             accm_s1;
  logic [WIDTH-1:0] g_q, acc_q;
  logic             carry_q, zero_q, ovf_q;

  logic [WIDTH-1:0] opa, res;
  logic [WIDTH:0]   sum;
  logic             cy, ov, shamt_ok;

  // S1: operands only move when a new op is presented
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      a_s1     <= '0;
      b_s1     <= '0;
      sel_s1   <= '0;
      accm_s1  <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], bus.in_valid};
      if (bus.in_valid) begin
        a_s1    <= bus.a;
        b_s1    <= bus.b;
        sel_s1  <= bus.sel;
        accm_s1 <= bus.acc_mode;
      end
    end
  end

  // acc is read here in S2, so chained acc ops see the previous write-back without a stall
  assign opa      = accm_s1 ? acc_q : a_s1;
  assign shamt_ok = ({1'b0, b_s1} < WLIM);

  always_comb begin
    sum = '0;
    res = '0;
    cy  = 1'b0;
    ov  = 1'b0;
    unique case (sel_s1)
      OP_ADD: begin
        sum = {1'b0, opa} + {1'b0, b_s1};
        res = sum[WIDTH-1:0];
        cy  = sum[WIDTH];
        ov  = (opa[WIDTH-1] == b_s1[WIDTH-1]) && (res[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_SUB: begin
        sum = {1'b0, opa} - {1'b0, b_s1};
        res = sum[WIDTH-1:0];
        cy  = sum[WIDTH];
        ov  = (opa[WIDTH-1] != b_s1[WIDTH-1]) && (res[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_AND: res = opa & b_s1;
      OP_OR:  res = opa | b_s1;
      OP_XOR: res = opa ^ b_s1;
      OP_NOT: res = ~opa;
      OP_SHL: res = shamt_ok ? (opa << b_s1) : '0;
      OP_SHR: res = shamt_ok ? (opa >> b_s1) : '0;
      default: res = '0;
    endcase
  end

  // S2: result and flags hold across bubbles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      g_q     <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (vld_pipe[1]) begin
      g_q     <= res;
      carry_q <= cy;
      zero_q  <= (res == '0);
      ovf_q   <= ov;
    end
  end

  // Clear wins over a same-edge write-back; the op computing this cycle still used the old acc
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         acc_q <= '0;
    else if (bus.acc_clr)               acc_q <= '0;
    else if (vld_pipe[1] && accm_s1)    acc_q <= res;
  end

  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.g         = g_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
  assign bus.acc       = acc_q;
endmodule
